// File: rtl/ldtu_stream_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ldtu_stream_decoder_pkg
//   Shared LiTe-DTU output word format: field widths, header codes, sample
//   counts per word type, word-type and FSM encodings, and a saturating
//   increment helper for the error/trailer counters.
//   The encoder side imports the same package, so both ends agree on the
//   format by construction.
// ---------------------------------------------------------------------------
package ldtu_stream_decoder_pkg;

    // Field widths (fixed by the LiTe-DTU output format)
    localparam int WORD_W    = 32;  // encoded word
    localparam int BAS_W     = 6;   // baseline sample
    localparam int SIG_W     = 13;  // signal sample {gain, adc[11:0]}
    localparam int ERR_CNT_W = 8;   // saturating counters
    localparam int HDR_W     = 8;   // header bits the classifier looks at

    // Header codes, left-aligned in the word
    localparam logic [5:0] HDR_SIGNAL  = 6'b001010;  // word[31:26]
    localparam logic [1:0] HDR_BASE    = 2'b01;      // word[31:30]
    localparam logic [3:0] HDR_PART    = 4'b1110;    // word[31:28], n in [27:24]
    localparam logic [3:0] HDR_TRAILER = 4'b1101;    // word[31:28]

    // Samples carried per word type
    localparam logic [2:0] N_BASE     = 3'd5;
    localparam logic [2:0] N_SIGNAL   = 3'd2;
    localparam logic [3:0] N_PART_MAX = 4'd4;

    typedef enum logic [2:0] {
        WT_BAD     = 3'd0,
        WT_BASE    = 3'd1,
        WT_PART    = 3'd2,
        WT_SIGNAL  = 3'd3,
        WT_TRAILER = 3'd4
    } word_type_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,  // no word held
        ST_UNPACK = 1'b1   // word held in the shadow register
    } state_e;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ldtu_header_classify.sv
// ---------------------------------------------------------------------------
// ldtu_header_classify
//   Combinational header decoder for one LiTe-DTU word.
//   Ports:
//     in_hdr     in   HDR_W  top byte of the word, word[31:24]
//     word_type  out  3      BAD / BASE / PART / SIGNAL / TRAILER
//     n_samples  out  3      samples the word carries (0 for TRAILER/BAD)
//   Only the top byte is needed to classify, so only that byte is wired in.
// ---------------------------------------------------------------------------
module ldtu_header_classify
    import ldtu_stream_decoder_pkg::*;
(
    input  logic [HDR_W-1:0] in_hdr,
    output word_type_e       word_type,
    output logic [2:0]       n_samples
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves it unassigned -- that is what keeps this free of latches.
        word_type = WT_BAD;
        n_samples = 3'd0;

        // Checked in priority order: SIGNAL's 6-bit code is tested first.
        if (in_hdr[7:2] == HDR_SIGNAL) begin
            word_type = WT_SIGNAL;
            n_samples = N_SIGNAL;
        end else if (in_hdr[7:6] == HDR_BASE) begin
            word_type = WT_BASE;
            n_samples = N_BASE;
        end else if (in_hdr[7:4] == HDR_PART) begin
            // A partial word with n outside 1..4 is malformed, stays BAD.
            if (in_hdr[3:0] != 4'd0 && in_hdr[3:0] <= N_PART_MAX) begin
                word_type = WT_PART;
                n_samples = in_hdr[2:0];
            end
        end else if (in_hdr[7:4] == HDR_TRAILER) begin
            word_type = WT_TRAILER;
        end
    end

endmodule

// File: rtl/ldtu_stream_decoder.sv
// ---------------------------------------------------------------------------
// ldtu_stream_decoder
//   Receive end of the LiTe-DTU baseline/signal encoder: unpacks the 32-bit
//   word stream into one 13-bit sample per clock.
//   Ports:
//     CLK           in   1          clock, all logic on posedge
//     reset         in   1          synchronous, active-high
//     in_word       in   WORD_W     encoded word
//     in_valid      in   1          in_word valid
//     in_ready      out  1          word taken when in_valid & in_ready
//     out_sample    out  SIG_W      {gain, adc[11:0]} or zero-extended baseline
//     out_baseline  out  1          sample came from a BASE/PART word
//     out_valid     out  1          out_sample valid
//     out_ready     in   1          sample taken when out_valid & out_ready
//     hdr_err       out  1          sticky unknown-header flag
//     err_cnt       out  ERR_CNT_W  saturating bad-header count
//     trl_cnt       out  ERR_CNT_W  saturating trailer count
//   Datapath: accepted word -> shadow register (shifted right one sample per
//   load) -> output register. rem_q counts samples still in the shadow
//   register, so the next word is taken on the cycle the last one moves to
//   the output register, keeping back-to-back words gapless.
// ---------------------------------------------------------------------------
module ldtu_stream_decoder
    import ldtu_stream_decoder_pkg::*;
(
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [WORD_W-1:0]    in_word,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SIG_W-1:0]     out_sample,
    output logic                 out_baseline,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 hdr_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ERR_CNT_W-1:0] trl_cnt
);

    state_e                 state_q, state_d;
    logic [WORD_W-1:0]      word_q, word_d;          // shadow register
    logic                   sig_q, sig_d;            // shadow holds a SIGNAL word
    logic [2:0]             rem_q, rem_d;            // samples left in shadow
    logic [SIG_W-1:0]       out_sample_q, out_sample_d;
    logic                   out_baseline_q, out_baseline_d;
    logic                   out_valid_q, out_valid_d;
    logic                   hdr_err_q, hdr_err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [ERR_CNT_W-1:0]   trl_cnt_q, trl_cnt_d;

    word_type_e             hdr_type;
    logic [2:0]             hdr_n;
    logic                   accept;
    logic                   load_out;

    ldtu_header_classify u_classify (
        .in_hdr    (in_word[WORD_W-1 -: HDR_W]),
        .word_type (hdr_type),
        .n_samples (hdr_n)
    );

    // Ready when empty, or when the last held sample moves out this cycle.
    assign in_ready = (state_q == ST_IDLE) || (rem_q == 3'd1 && out_ready);
    assign accept   = in_valid && in_ready;
    // The output register takes a new sample whenever it is free or drained.
    assign load_out = (state_q == ST_UNPACK) && (!out_valid_q || out_ready);

    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        sig_d          = sig_q;
        rem_d          = rem_q;
        out_sample_d   = out_sample_q;
        out_baseline_d = out_baseline_q;
        out_valid_d    = out_valid_q;
        hdr_err_d      = hdr_err_q;
        err_cnt_d      = err_cnt_q;
        trl_cnt_d      = trl_cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (load_out) begin
            // Sample k=0 always sits in the low bits; shifting the shadow
            // register brings the next one down.
            out_sample_d   = sig_q ? word_q[SIG_W-1:0]
                                   : {{(SIG_W-BAS_W){1'b0}}, word_q[BAS_W-1:0]};
            out_baseline_d = !sig_q;
            out_valid_d    = 1'b1;
            word_d         = sig_q ? (word_q >> SIG_W) : (word_q >> BAS_W);
            rem_d          = rem_q - 3'd1;
            if (rem_q == 3'd1) begin
                state_d = ST_IDLE;
            end
        end

        if (accept) begin
            case (hdr_type)
                WT_BASE, WT_PART, WT_SIGNAL: begin
                    word_d  = in_word;
                    sig_d   = (hdr_type == WT_SIGNAL);
                    rem_d   = hdr_n;
                    state_d = ST_UNPACK;
                end
                WT_TRAILER: begin
                    trl_cnt_d = sat_inc(trl_cnt_q);
                end
                default: begin
                    hdr_err_d = 1'b1;
                    err_cnt_d = sat_inc(err_cnt_q);
                end
            endcase
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rem_q          <= 3'd0;
            out_sample_q   <= '0;
            out_baseline_q <= 1'b0;
            out_valid_q    <= 1'b0;
            hdr_err_q      <= 1'b0;
            err_cnt_q      <= '0;
            trl_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            out_sample_q   <= out_sample_d;
            out_baseline_q <= out_baseline_d;
            out_valid_q    <= out_valid_d;
            hdr_err_q      <= hdr_err_d;
            err_cnt_q      <= err_cnt_d;
            trl_cnt_q      <= trl_cnt_d;
        end
    end

    // NOTE: the shadow register is pure datapath with no reset: it is only
    // read in UNPACK, and reset forces IDLE, which discards whatever it holds.
    always_ff @(posedge CLK) begin
        word_q <= word_d;
        sig_q  <= sig_d;
    end

    assign out_sample   = out_sample_q;
    assign out_baseline = out_baseline_q;
    assign out_valid    = out_valid_q;
    assign hdr_err      = hdr_err_q;
    assign err_cnt      = err_cnt_q;
    assign trl_cnt      = trl_cnt_q;

endmodule

// File: tb/tb_ldtu_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_ldtu_stream_decoder
//   Directed vectors for ldtu_stream_decoder. The stimulus thread pushes the
//   expected samples into sb_q before sending each word; the monitor pops and
//   compares every sample the DUT hands over (out_valid & out_ready).
//   Inputs change on the falling edge; the monitor samples 3 ns later,
//   well clear of the rising edge.
// ---------------------------------------------------------------------------
module tb_ldtu_stream_decoder;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] out_sample;
    logic        out_baseline;
    logic        out_valid;
    logic        out_ready;
    logic        hdr_err;
    logic [7:0]  err_cnt;
    logic [7:0]  trl_cnt;

    typedef struct packed {
        logic        bl;
        logic [12:0] s;
    } exp_t;

    exp_t sb_q[$];
    int   pop_cyc[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    ldtu_stream_decoder dut (
        .CLK          (CLK),
        .reset        (reset),
        .in_word      (in_word),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_sample   (out_sample),
        .out_baseline (out_baseline),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .hdr_err      (hdr_err),
        .err_cnt      (err_cnt),
        .trl_cnt      (trl_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_bas(input logic [5:0] v);
        sb_q.push_back({1'b1, 7'b0, v});
    endtask

    task automatic push_sig(input logic [12:0] v);
        sb_q.push_back({1'b0, v});
    endtask

    // Called just after a falling edge; returns on the falling edge that
    // follows the rising edge where the word was taken. in_valid stays high.
    task automatic send(input logic [31:0] w);
        int t = 0;
        in_word  = w;
        in_valid = 1'b1;
        #1;
        while (!in_ready && t < 100) begin
            @(negedge CLK);
            #1;
            t++;
        end
        check("send_timeout", 32'(in_ready), 32'd1);
        @(negedge CLK);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(negedge CLK);
            t++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #3;
            if (!reset && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_sample", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("sample", {18'b0, out_baseline, out_sample}, {18'b0, e});
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic ov_seen;

        // ---------------- reset state
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_out_valid",    32'(out_valid),    32'd0);
        check("rst_out_sample",   32'(out_sample),   32'd0);
        check("rst_out_baseline", 32'(out_baseline), 32'd0);
        check("rst_in_ready",     32'(in_ready),     32'd1);
        check("rst_hdr_err",      32'(hdr_err),      32'd0);
        check("rst_err_cnt",      32'(err_cnt),      32'd0);
        check("rst_trl_cnt",      32'(trl_cnt),      32'd0);
        reset = 1'b0;

        // ---------------- 1: BASE word, samples 1..5, latency
        for (int k = 1; k <= 5; k++) push_bas(6'(k));
        pop_cyc.delete();
        send(32'h4510_3081);
        in_valid = 1'b0;
        #1;
        check("t1_lat_n_valid", 32'(out_valid), 32'd0);
        @(negedge CLK);
        #1;
        check("t1_lat_n1_valid",  32'(out_valid),  32'd1);
        check("t1_lat_n1_sample", 32'(out_sample), 32'h1);
        wait_drain("t1_drain");
        check("t1_count", 32'(pop_cyc.size()), 32'd5);
        check("t1_gapless", 32'((pop_cyc.size() == 5) ? pop_cyc[4] - pop_cyc[0] : -1), 32'd4);

        // ---------------- 2: two SIGNAL words back-to-back
        push_sig(13'h0123);
        push_sig(13'h1ABC);
        push_sig(13'h1000);
        push_sig(13'h0FFF);
        pop_cyc.delete();
        send(32'h2B57_8123);
        in_word = 32'h29FF_F000;
        #1;
        check("t2_rdy_busy", 32'(in_ready), 32'd0);
        @(negedge CLK);
        #1;
        check("t2_rdy_last_a", 32'(in_ready), 32'd1);
        @(negedge CLK);
        in_valid = 1'b0;
        @(negedge CLK);
        #1;
        check("t2_rdy_last_b", 32'(in_ready), 32'd1);
        wait_drain("t2_drain");
        check("t2_gapless", 32'((pop_cyc.size() == 4) ? pop_cyc[3] - pop_cyc[0] : -1), 32'd3);

        // ---------------- 3: PART n=3, then PART n=0, n=5 (bad), n=1
        push_bas(6'd7);
        push_bas(6'd8);
        push_bas(6'd9);
        send(32'hE300_9207);
        send(32'hE000_0000);
        in_valid = 1'b0;
        check("t3_hdr_err",  32'(hdr_err), 32'd1);
        check("t3_err_cnt1", 32'(err_cnt), 32'd1);
        send(32'hE500_0000);
        in_valid = 1'b0;
        check("t3_err_cnt2", 32'(err_cnt), 32'd2);
        push_bas(6'h3F);
        send(32'hE100_003F);
        in_valid = 1'b0;
        wait_drain("t3_drain");
        check("t3_trl_cnt", 32'(trl_cnt), 32'd0);

        // ---------------- 4: out_ready low for 4 clocks mid-word
        for (int k = 10; k <= 14; k++) push_bas(6'(k));
        send(32'h4E34_C2CA);
        in_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            #1;
            check("t4_hold_sample", 32'(out_sample), 32'd11);
            check("t4_hold_valid",  32'(out_valid),  32'd1);
            check("t4_hold_ready",  32'(in_ready),   32'd0);
        end
        out_ready = 1'b1;
        wait_drain("t4_drain");

        // ---------------- 5: reset with rem=3 and in_valid high
        for (int k = 1; k <= 5; k++) push_bas(6'(k));
        send(32'h4510_3081);
        in_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        reset    = 1'b1;
        in_word  = 32'h5961_7595;
        in_valid = 1'b1;
        @(negedge CLK);
        #1;
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_in_ready",  32'(in_ready),  32'd1);
        check("t5_err_cnt",   32'(err_cnt),   32'd0);
        check("t5_trl_cnt",   32'(trl_cnt),   32'd0);
        check("t5_hdr_err",   32'(hdr_err),   32'd0);
        reset = 1'b0;
        sb_q.delete();
        for (int k = 21; k <= 25; k++) push_bas(6'(k));
        pop_cyc.delete();
        send(32'h5961_7595);
        in_valid = 1'b0;
        wait_drain("t5_drain");
        check("t5_gapless", 32'((pop_cyc.size() == 5) ? pop_cyc[4] - pop_cyc[0] : -1), 32'd4);

        // ---------------- 6: counter saturation
        ov_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            send(32'hD000_0000);
            ov_seen |= out_valid;
            if (i == 253) check("t6_trl_fe", 32'(trl_cnt), 32'hFE);
        end
        for (int i = 0; i < 300; i++) begin
            send((i % 2 == 0) ? 32'h0000_0000 : 32'hF000_0000);
            ov_seen |= out_valid;
            if (i == 253) check("t6_err_fe", 32'(err_cnt), 32'hFE);
        end
        in_valid = 1'b0;
        check("t6_trl_sat", 32'(trl_cnt), 32'hFF);
        check("t6_err_sat", 32'(err_cnt), 32'hFF);
        check("t6_hdr_err", 32'(hdr_err), 32'd1);
        check("t6_no_out",  32'(ov_seen), 32'd0);

        repeat (3) @(negedge CLK);
        wait_drain("final_drain");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
